// File: rtl/ioctl_upload_port.sv
// HPS ioctl upload responder: answers each ioctl_rd strobe with one byte read from a
// fixed-latency synchronous memory. Define IOCTL_UPLOAD_CSUM_EN for the running checksum.
module ioctl_upload_port #(
  parameter int ADDR_W  = 16,
  parameter int SIZE    = 65536,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic [24:0]       byte_cnt,
  output logic              done,
  output logic [7:0]        csum
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE
  } state_t;

  localparam logic [25:0] SIZE_W   = 26'(SIZE);
  localparam logic [2:0]  LAT_INIT = 3'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("ioctl_upload_port: MEM_LAT must be in 1..4");
  end
  if (longint'(SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_size
    $error("ioctl_upload_port: SIZE must not exceed 2**ADDR_W");
  end

  state_t      state, state_next;
  logic [2:0]  lat_cnt, lat_next;
  logic        upload_q;
  logic        in_range;
  logic        accept;
  logic        capture;
  logic        fill;
  logic        serve;
  logic        sess_rise;
  logic        sess_fall;
  logic [7:0]  serve_data;
  logic [24:0] cnt_base;
  logic [24:0] cnt_next;

  assign in_range  = ({1'b0, ioctl_addr} < SIZE_W);
  assign sess_rise = ioctl_upload & ~upload_q;
  assign sess_fall = ~ioctl_upload & upload_q;
  assign done      = sess_fall;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    fill       = 1'b0;
    ioctl_wait = 1'b1;
    case (state)
      IDLE: begin
        // Strobes outside IDLE are protocol violations and simply never reach here.
        ioctl_wait = ioctl_rd & ioctl_upload & in_range;
        if (ioctl_rd && ioctl_upload) begin
          if (in_range) begin
            accept     = 1'b1;
            lat_next   = LAT_INIT;
            state_next = FETCH;
          end else begin
            fill = 1'b1;
          end
        end
      end
      FETCH: begin
        lat_next = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A session start clears the count before any byte served on the same edge is added.
  always_comb begin
    serve      = capture | fill;
    serve_data = capture ? mem_dout : 8'hFF;
    cnt_base   = sess_rise ? 25'd0 : byte_cnt;
    cnt_next   = serve ? cnt_base + 25'd1 : cnt_base;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      upload_q  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      ioctl_din <= 8'h00;
      byte_cnt  <= 25'd0;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_next;
      upload_q <= ioctl_upload;
      mem_rd   <= accept;
      byte_cnt <= cnt_next;
      if (accept) begin
        mem_addr <= ioctl_addr[ADDR_W-1:0];
      end
      if (serve) begin
        ioctl_din <= serve_data;
      end
    end
  end

`ifdef IOCTL_UPLOAD_CSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_base;
  logic [7:0] csum_next;

  always_comb begin
    csum_base = sess_rise ? 8'h00 : csum_q;
    csum_next = serve ? csum_base + serve_data : csum_base;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_next;
    end
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

endmodule
